// File: rtl/uart_ecc_bridge.sv
// uart_ecc_bridge
//   Buffered Hamming(7,4) single-error-correcting bridge between the UART
//   receiver and transmitter. Received bytes are queued in a small FIFO. Each
//   byte is popped, its 7-bit codeword corrected, and the result handed to the
//   transmitter through a start/busy handshake. Optionally, an 8'hFF tag byte
//   follows any byte that needed a correction.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   OUT_MODE  0: send {1'b0, corrected codeword}; 1: send {4'h0, data nibble}
//   ERR_TAG   1: follow corrected bytes with 8'hFF; 0: never tag
//
// Ports
//   clk         system clock, posedge
//   rst_n       asynchronous active-low reset
//   rx_valid    one-cycle strobe, rx_data valid
//   rx_data     received byte (bit 7 ignored)
//   tx_busy     transmitter busy
//   tx_start    one-cycle start pulse to transmitter
//   tx_data     byte to transmit, stable from tx_start until next load
//   err_count   saturating count of corrected words
//   overflow    sticky, a byte was dropped because the FIFO was full
//   fifo_level  current FIFO occupancy
module uart_ecc_bridge #(
  parameter int DEPTH    = 4,
  parameter int OUT_MODE = 0,
  parameter int ERR_TAG  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic [15:0]              err_count,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, SEND, GUARD, WAIT, TAG} state_t;

  state_t        state;
  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          err_r;

  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic [6:0]    code;
  logic [2:0]    syn;
  logic [6:0]    flip;
  logic [6:0]    fixed;
  logic [7:0]    dec_byte;

  // Bit 7 of the received byte carries no information.
  logic          rx_bit7_unused;
  assign rx_bit7_unused = rx_data[7];

  assign full  = (fifo_level == FULL_LEVEL);
  assign empty = (fifo_level == '0);
  assign pop   = (state == IDLE) && !empty;
  // A pop in the same cycle frees a slot, so a write while full still lands.
  assign push  = rx_valid && (!full || pop);

  // The start pulse goes out in the first SEND cycle with the transmitter idle,
  // so it can never coincide with busy and the FSM leaves SEND immediately.
  assign tx_start = (state == SEND) && !tx_busy;

  // Decode the codeword at the head of the FIFO.
  always_comb begin
    code   = mem[rd_ptr];
    syn[0] = code[0] ^ code[2] ^ code[4] ^ code[6];
    syn[1] = code[1] ^ code[2] ^ code[5] ^ code[6];
    syn[2] = code[3] ^ code[4] ^ code[5] ^ code[6];
    flip   = (syn == 3'd0) ? 7'd0 : 7'(7'd1 << (syn - 3'd1));
    fixed  = code ^ flip;
    if (OUT_MODE == 1) begin
      dec_byte = {4'h0, fixed[6], fixed[5], fixed[4], fixed[2]};
    end else begin
      dec_byte = {1'b0, fixed};
    end
  end

  // Storage has no reset so it can map onto memory primitives.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rx_data[6:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        fifo_level <= fifo_level + 1'b1;
      end else if (pop && !push) begin
        fifo_level <= fifo_level - 1'b1;
      end
      if (rx_valid && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_data   <= 8'h00;
      err_r     <= 1'b0;
      err_count <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            tx_data <= dec_byte;
            err_r   <= (syn != 3'd0);
            if ((syn != 3'd0) && (err_count != 16'hFFFF)) begin
              err_count <= err_count + 16'd1;
            end
            state <= SEND;
          end
        end
        SEND: begin
          if (!tx_busy) state <= GUARD;
        end
        // Gives the transmitter a cycle to raise busy before it is trusted.
        GUARD: state <= WAIT;
        WAIT: begin
          if (!tx_busy) begin
            state <= ((ERR_TAG != 0) && err_r) ? TAG : IDLE;
          end
        end
        TAG: begin
          tx_data <= 8'hFF;
          err_r   <= 1'b0;
          state   <= SEND;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ecc_bridge.sv
// Bench for uart_ecc_bridge. Two instances share clock and reset:
//   dut_a: DEPTH 4, OUT_MODE 0, ERR_TAG 1
//   dut_b: DEPTH 4, OUT_MODE 1, ERR_TAG 0
// A simple transmitter model drives tx_busy for BUSY_LEN cycles after each
// accepted start (and can be forced high). Every accepted received byte is
// turned into its expected transmit bytes by a Hamming model. The negedge
// monitor compares each tx_start against that queue.
module tb_uart_ecc_bridge;
  localparam int BUSY_LEN = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid   [2];
  logic [7:0]  rx_data    [2];
  logic        tx_busy    [2];
  logic        tx_start   [2];
  logic [7:0]  tx_data    [2];
  logic [15:0] err_count  [2];
  logic        overflow   [2];
  logic [2:0]  fifo_level [2];
  logic        force_busy [2];
  logic        prev_start [2];
  int          busy_cnt   [2];
  int          model_ec   [2];

  int tests = 0;
  int fails = 0;

  // Expected transmit entries: {err_count at start, byte}.
  logic [23:0] exp_q0[$];
  logic [23:0] exp_q1[$];

  always #5 clk = ~clk;

  uart_ecc_bridge #(.DEPTH(4), .OUT_MODE(0), .ERR_TAG(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid[0]), .rx_data(rx_data[0]),
    .tx_busy(tx_busy[0]), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
    .err_count(err_count[0]), .overflow(overflow[0]), .fifo_level(fifo_level[0])
  );

  uart_ecc_bridge #(.DEPTH(4), .OUT_MODE(1), .ERR_TAG(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid[1]), .rx_data(rx_data[1]),
    .tx_busy(tx_busy[1]), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
    .err_count(err_count[1]), .overflow(overflow[1]), .fifo_level(fifo_level[1])
  );

  // Transmitter model.
  assign tx_busy[0] = force_busy[0] || (busy_cnt[0] != 0);
  assign tx_busy[1] = force_busy[1] || (busy_cnt[1] != 0);

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (tx_start[i] && !tx_busy[i]) busy_cnt[i] <= BUSY_LEN;
      else if (busy_cnt[i] != 0)      busy_cnt[i] <= busy_cnt[i] - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hamming model: the syndrome is the XOR of the positions of all set bits.
  function automatic int model_syn(input logic [7:0] r);
    int s = 0;
    for (int k = 1; k <= 7; k++) if (r[k-1]) s = s ^ k;
    return s;
  endfunction

  function automatic logic [7:0] model_out(input logic [7:0] r, input int mode);
    logic [6:0] c = r[6:0];
    int s = model_syn(r);
    if (s != 0) c[s-1] = ~c[s-1];
    if (mode == 1) return {4'h0, c[6], c[5], c[4], c[2]};
    return {1'b0, c};
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic exp_add(input int i, input logic [7:0] b);
    if (i == 0) exp_q0.push_back({model_ec[i][15:0], b});
    else        exp_q1.push_back({model_ec[i][15:0], b});
  endtask

  // Instance 0 runs OUT_MODE 0 with tags, instance 1 OUT_MODE 1 without.
  task automatic model_accept(input int i, input logic [7:0] r);
    bit err = (model_syn(r) != 0);
    if (err) model_ec[i]++;
    exp_add(i, model_out(r, i));
    if (err && i == 0) exp_add(i, 8'hFF);
  endtask

  // Called at posedge+1; drives rx_valid for one cycle.
  task automatic send_rx(input int i, input logic [7:0] d, input bit dropped);
    rx_valid[i] = 1'b1;
    rx_data[i]  = d;
    if (!dropped) model_accept(i, d);
    @(posedge clk); #1;
    rx_valid[i] = 1'b0;
  endtask

  task automatic wait_drain(input int i, input int max_cycles);
    int n = 0;
    while (qsize(i) != 0 && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("drain_dut%0d", i), qsize(i), 0);
  endtask

  task automatic wait_start(input int i, input int max_cycles);
    int n = 0;
    while (!tx_start[i] && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("start_seen_dut%0d", i), tx_start[i], 1);
  endtask

  // Compare process: every start pulse is checked against the model queue.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        prev_start[i] = 1'b0;
      end else begin
        if (tx_start[i]) begin
          logic [23:0] e;
          check($sformatf("start_not_busy_dut%0d", i), tx_busy[i], 0);
          check($sformatf("start_not_back_to_back_dut%0d", i), prev_start[i], 0);
          if (qsize(i) == 0) begin
            check($sformatf("unexpected_start_dut%0d", i), {24'h0, tx_data[i]}, 32'h1FF);
          end else begin
            e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            $display("[TB] dut%0d tx byte %02h (model %02h) err_count %0d (model %0d)",
                     i, tx_data[i], e[7:0], err_count[i], e[23:8]);
            check($sformatf("tx_data_dut%0d", i), tx_data[i], e[7:0]);
            check($sformatf("err_count_at_start_dut%0d", i), err_count[i], e[23:8]);
          end
        end
        prev_start[i] = tx_start[i];
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts;
    for (int i = 0; i < 2; i++) begin
      rx_valid[i] = 1'b0; rx_data[i] = 8'h00; force_busy[i] = 1'b0;
      busy_cnt[i] = 0; model_ec[i] = 0; prev_start[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_start", tx_start[0], 0);
    check("reset_tx_data", tx_data[0], 8'h00);
    check("reset_err_count", err_count[0], 0);
    check("reset_overflow", overflow[0], 0);
    check("reset_level", fifo_level[0], 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the model with hand-computed values.
    check("model_syn_76", model_syn(8'h76), 5);
    check("model_76", model_out(8'h76, 0), 8'h66);
    check("model_E7_nibble", model_out(8'hE7, 1), 8'h0D);
    check("model_7F", model_out(8'h7F, 0), 8'h7F);
    check("model_syn_66", model_syn(8'h66), 0);

    // Clean word with exact latency: write edge 0, pop edge 1, start cycle 2.
    send_rx(0, 8'h66, 0);
    check("lat_level_c1", fifo_level[0], 1);
    check("lat_no_start_c1", tx_start[0], 0);
    @(posedge clk); #1;
    check("lat_start_c2", tx_start[0], 1);
    check("lat_data_c2", tx_data[0], 8'h66);
    check("lat_level_c2", fifo_level[0], 0);
    wait_drain(0, 50);
    repeat (20) @(posedge clk);
    #1;
    check("clean_err_count", err_count[0], 0);

    // Single error with tag.
    send_rx(0, 8'h76, 0);
    wait_drain(0, 100);
    repeat (12) @(posedge clk);
    #1;
    check("err_count_after_76", err_count[0], 1);

    // Nibble mode, no tag.
    send_rx(1, 8'hE7, 0);
    wait_drain(1, 100);
    repeat (20) @(posedge clk);
    #1;
    check("err_count_b_after_E7", err_count[1], 1);

    // Backpressure: the first byte is popped into tx_data right away, so two
    // remain queued while the transmitter is held busy.
    force_busy[0] = 1'b1;
    send_rx(0, 8'h66, 0);
    send_rx(0, 8'h00, 0);
    send_rx(0, 8'h7F, 0);
    check("bp_level", fifo_level[0], 2);
    starts = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (tx_start[0]) starts++;
    end
    check("bp_no_start_while_held", starts, 0);
    check("bp_level_held", fifo_level[0], 2);
    force_busy[0] = 1'b0;
    wait_drain(0, 200);
    repeat (12) @(posedge clk);
    #1;
    check("bp_level_empty", fifo_level[0], 0);

    // Overflow: one byte in flight plus four queued, the sixth is dropped.
    force_busy[0] = 1'b1;
    send_rx(0, 8'h00, 0);
    send_rx(0, 8'h7F, 0);
    send_rx(0, 8'h66, 0);
    send_rx(0, 8'h33, 0);
    send_rx(0, 8'h55, 0);
    check("ovf_level_full", fifo_level[0], 4);
    check("ovf_not_yet", overflow[0], 0);
    send_rx(0, 8'h4B, 1);
    check("ovf_set", overflow[0], 1);
    check("ovf_level_still_full", fifo_level[0], 4);
    // Release: start goes out this cycle; the next pop falls BUSY_LEN+2 later.
    force_busy[0] = 1'b0;
    #1;
    check("ovf_release_start", tx_start[0], 1);
    repeat (BUSY_LEN + 2) @(posedge clk);
    #1;
    send_rx(0, 8'h2D, 0);
    check("ovf_write_with_pop_level", fifo_level[0], 4);
    wait_drain(0, 300);
    repeat (12) @(posedge clk);
    #1;
    check("ovf_level_drained", fifo_level[0], 0);
    check("ovf_sticky", overflow[0], 1);

    // Asynchronous reset during WAIT of an errored byte: tag abandoned.
    send_rx(0, 8'h76, 0);
    wait_start(0, 20);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_tx_start", tx_start[0], 0);
    check("arst_level", fifo_level[0], 0);
    check("arst_err_count", err_count[0], 0);
    check("arst_tx_data", tx_data[0], 8'h00);
    check("arst_overflow", overflow[0], 0);
    exp_q0.delete();
    exp_q1.delete();
    model_ec[0] = 0;
    model_ec[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    // Normal operation resumes after reset.
    send_rx(0, 8'h66, 0);
    wait_drain(0, 50);
    repeat (12) @(posedge clk);
    #1;
    check("post_reset_err_count", err_count[0], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
